change_dispenser: RTL



---
 rtl/change_dispenser.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out one coin at a time over a
// four-phase req/ack handshake. Greedy: 5-unit coins while remaining >= 5,
// then 1-unit coins. Drives the live remaining-change code for the display.
// Any handshake wait longer than ACK_TIMEOUT cycles parks the block in FAULT
// until clear.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | clamped amount latched; decide first coin or finish
// REQ     | coin_req high, waiting for coin_ack high
// RELEASE | coin_req low, waiting for coin_ack low
// DONE    | payout complete; done pulses on the following cycle
// FAULT   | ejector timed out; change_left holds the unpaid amount
module change_dispenser #(
  parameter int MAX_CHANGE  = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       clear,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic       coin_sel,
  output logic [3:0] change_left,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    MAXV    = 4'(MAX_CHANGE);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, RELEASE, DONE, FAULT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          req_n, sel_n, busy_n, done_n, err_n;
  logic [3:0]    left_n;

  // State, wait counter and every output are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      coin_req    <= 1'b0;
      coin_sel    <= 1'b0;
      change_left <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      coin_req    <= req_n;
      coin_sel    <= sel_n;
      change_left <= left_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

  // Next state and next output values; the counter restarts on each entry
  // to REQ/RELEASE and a fault is raised on its ACK_TIMEOUT-th waiting cycle
  // unless the awaited ack level arrives on that same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = coin_req;
    sel_n   = coin_sel;
    left_n  = change_left;
    case (state)
      IDLE: begin
        if (start) begin
          left_n  = (amount > MAXV) ? MAXV : amount;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (change_left == 4'd0) begin
          state_n = DONE;
        end else begin
          sel_n   = (change_left >= 4'd5);
          req_n   = 1'b1;
          cnt_n   = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        if (coin_ack) begin
          req_n   = 1'b0;
          left_n  = change_left - (coin_sel ? 4'd5 : 4'd1);
          cnt_n   = '0;
          state_n = RELEASE;
        end else if (cnt == TO_LAST) begin
          req_n   = 1'b0;
          state_n = FAULT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE: begin
        if (!coin_ack) begin
          if (change_left == 4'd0) begin
            state_n = DONE;
          end else begin
            sel_n   = (change_left >= 4'd5);
            req_n   = 1'b1;
            cnt_n   = '0;
            state_n = REQ;
          end
        end else if (cnt == TO_LAST) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      FAULT: begin
        if (clear) begin
          left_n  = 4'd0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // busy covers the payout through DONE so it falls on the edge done rises
    busy_n = (state_n == LOAD) || (state_n == REQ) ||
             (state_n == RELEASE) || (state_n == DONE);
    done_n = (state == DONE);
    err_n  = (state_n == FAULT);
  end

endmodule
